voxel_sequencer: RTL

- Frame-level controller directly upstream of the pixel_shader array.
- Walks the voxel RAM twice per frame, broadcasting one voxel at a time on the shared shader bus:
  - rasterize pass: do_rasterize pulses;
  - shade pass: do_shade pulses plus a palette lookup.
- Waits for the array-wide done signals between voxels.
- Host side is a start/frame_done handshake; memory side is two 1-cycle-latency read ports.

---
 rtl/voxel_pkg.sv | 34 +++
 rtl/seq_watchdog.sv | 32 +++
 rtl/voxel_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/voxel_pkg.sv
// Shared widths, voxel word layout and sequencer state encoding for the
// voxel_sequencer / pixel_shader pair.
package voxel_pkg;

    localparam int DEF_COORD_BITS     = 8;
    localparam int DEF_PALETTE_BITS   = 8;
    localparam int DEF_PIXEL_BITS     = 8;
    localparam int DEF_ADDR_BITS      = 16;
    localparam int DEF_VOXEL_BITS     = 3*DEF_COORD_BITS + DEF_PALETTE_BITS;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    // x sits in the MSBs of the RAM word
    typedef struct packed {
        logic [DEF_COORD_BITS-1:0]   x;
        logic [DEF_COORD_BITS-1:0]   y;
        logic [DEF_COORD_BITS-1:0]   z;
        logic [DEF_PALETTE_BITS-1:0] id;
    } voxel_t;

    typedef enum logic [3:0] {
        IDLE,
        R_FETCH,
        R_LOAD,
        R_ISSUE,
        R_WAIT,
        S_FETCH,
        S_LOAD,
        S_PAL,
        S_ISSUE,
        S_WAIT,
        DONE
    } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Wait-state watchdog for voxel_sequencer; only built when
// VOXEL_SEQ_TIMEOUT_EN is defined.
`ifdef VOXEL_SEQ_TIMEOUT_EN
module seq_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    // fires on the LIMIT-th consecutive enabled cycle
    assign expired = enable && (count == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/voxel_sequencer.sv
// Frame controller: walks voxel RAM for a rasterize pass then a shade pass.
// Optional wait-state watchdog enabled by VOXEL_SEQ_TIMEOUT_EN.
module voxel_sequencer
    import voxel_pkg::*;
#(
`ifdef VOXEL_SEQ_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
`endif
    parameter int COORD_BITS   = DEF_COORD_BITS,
    parameter int PALETTE_BITS = DEF_PALETTE_BITS,
    parameter int PIXEL_BITS   = DEF_PIXEL_BITS,
    parameter int ADDR_BITS    = DEF_ADDR_BITS,
    parameter int VOXEL_BITS   = 3*COORD_BITS + PALETTE_BITS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_BITS-1:0]    voxel_count,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    error,
    output logic                    vram_rd,
    output logic [ADDR_BITS-1:0]    vram_addr,
    input  logic [VOXEL_BITS-1:0]   vram_data,
    output logic                    pal_rd,
    output logic [PALETTE_BITS-1:0] pal_addr,
    input  logic [PIXEL_BITS-1:0]   pal_data,
    output logic [COORD_BITS-1:0]   voxel_x,
    output logic [COORD_BITS-1:0]   voxel_y,
    output logic [COORD_BITS-1:0]   voxel_z,
    output logic [PALETTE_BITS-1:0] voxel_id,
    output logic [PIXEL_BITS-1:0]   palette_entry,
    output logic                    do_rasterize,
    output logic                    do_shade,
    input  logic                    all_rasterized,
    input  logic                    all_shaded
);

    seq_state_t state;
    seq_state_t state_next;

    logic [ADDR_BITS-1:0] idx;
    logic [ADDR_BITS-1:0] idx_next;
    logic [ADDR_BITS-1:0] count_q;

    logic load_voxel;
    logic load_pal;
    logic last;
    logic accept;
    logic wait_done;
    logic expired;
    logic timeout;

    assign accept    = (state == IDLE) && start;
    assign last      = (idx == count_q - ADDR_BITS'(1));
    assign wait_done = ((state == R_WAIT) && all_rasterized)
                    || ((state == S_WAIT) && all_shaded);
    assign timeout   = expired && !wait_done;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        load_voxel = 1'b0;
        load_pal   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    idx_next   = '0;
                    state_next = (voxel_count == '0) ? DONE : R_FETCH;
                end
            end
            R_FETCH: state_next = R_LOAD;
            R_LOAD: begin
                load_voxel = 1'b1;
                state_next = R_ISSUE;
            end
            R_ISSUE: state_next = R_WAIT;
            R_WAIT: begin
                if (all_rasterized) begin
                    if (last) begin
                        idx_next   = '0;
                        state_next = S_FETCH;
                    end else begin
                        idx_next   = idx + 1'b1;
                        state_next = R_FETCH;
                    end
                end else if (timeout) begin
                    state_next = DONE;
                end
            end
            S_FETCH: state_next = S_LOAD;
            S_LOAD: begin
                load_voxel = 1'b1;
                state_next = S_PAL;
            end
            S_PAL: begin
                load_pal   = 1'b1;
                state_next = S_ISSUE;
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (all_shaded) begin
                    if (last) begin
                        idx_next   = '0;
                        state_next = DONE;
                    end else begin
                        idx_next   = idx + 1'b1;
                        state_next = S_FETCH;
                    end
                end else if (timeout) begin
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // broadcast registers only move in the LOAD / PAL states
    always_ff @(posedge clock) begin
        if (!reset) begin
            idx           <= '0;
            count_q       <= '0;
            voxel_x       <= '0;
            voxel_y       <= '0;
            voxel_z       <= '0;
            voxel_id      <= '0;
            palette_entry <= '0;
        end else begin
            idx <= idx_next;
            if (accept) begin
                count_q <= voxel_count;
            end
            if (load_voxel) begin
                voxel_x  <= vram_data[VOXEL_BITS-1 -: COORD_BITS];
                voxel_y  <= vram_data[VOXEL_BITS-COORD_BITS-1 -: COORD_BITS];
                voxel_z  <= vram_data[PALETTE_BITS+COORD_BITS-1 -: COORD_BITS];
                voxel_id <= vram_data[PALETTE_BITS-1:0];
            end
            if (load_pal) begin
                palette_entry <= pal_data;
            end
        end
    end

    assign busy         = (state != IDLE);
    assign frame_done   = (state == DONE);
    assign vram_rd      = (state == R_FETCH) || (state == S_FETCH);
    assign vram_addr    = vram_rd ? idx : '0;
    assign pal_rd       = (state == S_LOAD);
    assign pal_addr     = pal_rd ? vram_data[PALETTE_BITS-1:0] : '0;
    assign do_rasterize = (state == R_ISSUE);
    assign do_shade     = (state == S_ISSUE);

`ifdef VOXEL_SEQ_TIMEOUT_EN
    logic error_q;

    seq_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   ((state == R_ISSUE) || (state == S_ISSUE)),
        .enable  ((state == R_WAIT) || (state == S_WAIT)),
        .expired (expired)
    );

    // sticky until the host starts another frame
    always_ff @(posedge clock) begin
        if (!reset) begin
            error_q <= 1'b0;
        end else if (accept) begin
            error_q <= 1'b0;
        end else if (timeout) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    assign expired = 1'b0;
    assign error   = 1'b0;
`endif

endmodule
